// File: rtl/ifetch_pkg.sv
// ============================================================================
//  Module      : ifetch_pkg
//  Description : Shared definitions for the LEGv8 instruction-fetch stage:
//                FSM state encoding, the architectural NOP and the default
//                address / instruction widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

   localparam int DEFAULT_ADDR_W  = 64;
   localparam int DEFAULT_INSTR_W = 32;

   // LEGv8 NOP, loaded into the IF/ID register on reset so decode never sees
   // an undefined instruction.
   localparam logic [31:0] LEGV8_NOP = 32'hD503201F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } ifetch_state_t;

endpackage : ifetch_pkg

`default_nettype wire

// File: rtl/ifetch_perf_counter.sv
// ============================================================================
//  Module      : ifetch_perf_counter
//  Description : 32-bit event counter with enable that sticks at all-ones
//                instead of wrapping.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset (count -> 0)
//                en    - count this cycle
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_perf_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [31:0] count
);

   localparam logic [31:0] c_MAX = 32'hFFFF_FFFF;

   logic [31:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 32'd0;
      end else if (en && (r_count != c_MAX)) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign count = r_count;

endmodule : ifetch_perf_counter

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : LEGv8 instruction-fetch stage. Samples the PC, issues a
//                req/ack fetch to instruction memory, captures the returned
//                word into the IF/ID register and hands it to decode with a
//                valid/ready handshake. Drives the PC write enable so the PC
//                only advances on a completed fetch or on a branch flush.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                pc_in                - current PC (PC register output)
//                pc_write             - PC write enable (combinational)
//                imem_req/imem_addr   - memory request and address
//                imem_ack/imem_rdata  - memory completion and data
//                flush                - branch redirect
//                id_ready             - decode can accept
//                if_valid/if_instr/if_pc - IF/ID register to decode
//                perf_stall_cnt       - memory stall cycles (IFETCH_PERF_EN)
//  Config      : define IFETCH_PERF_EN to add the stall counter output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
   import ifetch_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int INSTR_W = DEFAULT_INSTR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic               pc_write,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               flush,
   input  logic               id_ready,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]        perf_stall_cnt
`endif
);

   ifetch_state_t      r_state;
   logic               r_imem_req;
   logic [ADDR_W-1:0]  r_imem_addr;
   logic               r_if_valid;
   logic [INSTR_W-1:0] r_if_instr;
   logic [ADDR_W-1:0]  r_if_pc;

   // The PC advances in the ack cycle so that it already holds the next
   // address in the first HOLD cycle. In DRAIN the ack belongs to a
   // squashed fetch, so only a flush may move the PC there.
   assign pc_write = flush | ((r_state == REQ) & imem_ack);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_imem_req  <= 1'b0;
         r_imem_addr <= '0;
         r_if_valid  <= 1'b0;
         r_if_instr  <= INSTR_W'(LEGV8_NOP);
         r_if_pc     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // A flush here only redirects the PC; the fetch starts once
               // the redirect has landed.
               if (!flush) begin
                  r_imem_addr <= pc_in;
                  r_imem_req  <= 1'b1;
                  r_state     <= REQ;
               end
            end

            REQ: begin
               if (imem_ack) begin
                  r_imem_req <= 1'b0;
                  if (flush) begin
                     r_state <= IDLE;
                  end else begin
                     r_if_instr <= imem_rdata;
                     r_if_pc    <= r_imem_addr;
                     r_if_valid <= 1'b1;
                     r_state    <= HOLD;
                  end
               end else if (flush) begin
                  // The memory still owes us a response; keep the request
                  // up and throw the data away when it arrives.
                  r_state <= DRAIN;
               end
            end

            DRAIN: begin
               if (imem_ack) begin
                  r_imem_req <= 1'b0;
                  r_state    <= IDLE;
               end
            end

            HOLD: begin
               if (flush) begin
                  r_if_valid <= 1'b0;
                  r_state    <= IDLE;
               end else if (id_ready) begin
                  // Transfer to decode and start the next fetch from the
                  // PC that was updated in the ack cycle.
                  r_if_valid  <= 1'b0;
                  r_imem_addr <= pc_in;
                  r_imem_req  <= 1'b1;
                  r_state     <= REQ;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_imem_addr;
   assign if_valid  = r_if_valid;
   assign if_instr  = r_if_instr;
   assign if_pc     = r_if_pc;

`ifdef IFETCH_PERF_EN
   logic w_stall;

   assign w_stall = r_imem_req & ~imem_ack &
                    ((r_state == REQ) | (r_state == DRAIN));

   ifetch_perf_counter u_perf_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_stall),
      .count (perf_stall_cnt)
   );
`endif

endmodule : instr_fetch_unit

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed, table-driven bench for instr_fetch_unit. An
//                external PC register (+4 adder, flush target mux) is
//                modelled here and fed back into pc_in.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'hD503201F;
   localparam logic [31:0] A0  = 32'h8B020020;
   localparam logic [31:0] A1  = 32'hCB030041;
   localparam logic [31:0] A2  = 32'hF8400062;
   localparam logic [31:0] A3  = 32'hB4000083;
   localparam logic [31:0] A4  = 32'h910010A4;
   localparam logic [31:0] BAD = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] pc_in;
   logic        pc_write;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        flush;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic [63:0] tgt;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_in      (pc_in),
      .pc_write   (pc_write),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .flush      (flush),
      .id_ready   (id_ready),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc)
`ifdef IFETCH_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // External PC register: redirect on flush, otherwise +4 per completed fetch.
   initial pc_in = 64'd0;
   always @(posedge clk) begin
      if (pc_write) pc_in <= flush ? tgt : pc_in + 64'd4;
   end

   typedef struct {
      logic        f;
      logic        rdy;
      logic        ack;
      logic [31:0] rdata;
      logic [63:0] tgt;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [63:0] e_pc;
      logic        e_pcw;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic f, input logic rdy, input logic ack,
                               input logic [31:0] rdata, input logic [63:0] t,
                               input logic e_req, input logic [63:0] e_addr,
                               input logic e_valid, input logic [31:0] e_instr,
                               input logic [63:0] e_pc, input logic e_pcw);
      vec_t v;
      v.f = f; v.rdy = rdy; v.ack = ack; v.rdata = rdata; v.tgt = t;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_instr = e_instr; v.e_pc = e_pc; v.e_pcw = e_pcw;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      //   f rdy ack rdata tgt      | req addr   vld instr ifpc   pcw
      // zero-wait fetches from 0, 4, 8
      add(0, 1, 0, 0,   0,        0, 64'h0,   0, NOP, 64'h0,   0); // 0  IDLE
      add(0, 1, 1, A0,  0,        1, 64'h0,   0, NOP, 64'h0,   1); // 1  REQ ack
      add(0, 1, 0, 0,   0,        0, 64'h0,   1, A0,  64'h0,   0); // 2  HOLD
      add(0, 1, 1, A1,  0,        1, 64'h4,   0, A0,  64'h0,   1); // 3
      add(0, 1, 0, 0,   0,        0, 64'h4,   1, A1,  64'h4,   0); // 4
      add(0, 1, 1, A2,  0,        1, 64'h8,   0, A1,  64'h4,   1); // 5
      // decode stalls 5 cycles in HOLD (stray ack ignored)
      add(0, 0, 0, 0,   0,        0, 64'h8,   1, A2,  64'h8,   0); // 6
      add(0, 0, 1, BAD, 0,        0, 64'h8,   1, A2,  64'h8,   0); // 7
      add(0, 0, 0, 0,   0,        0, 64'h8,   1, A2,  64'h8,   0); // 8
      add(0, 0, 0, 0,   0,        0, 64'h8,   1, A2,  64'h8,   0); // 9
      add(0, 0, 0, 0,   0,        0, 64'h8,   1, A2,  64'h8,   0); // 10
      add(0, 1, 0, 0,   0,        0, 64'h8,   1, A2,  64'h8,   0); // 11 transfer
      // ack delayed 3 cycles
      add(0, 1, 0, 0,   0,        1, 64'hC,   0, A2,  64'h8,   0); // 12
      add(0, 1, 0, 0,   0,        1, 64'hC,   0, A2,  64'h8,   0); // 13
      add(0, 1, 0, 0,   0,        1, 64'hC,   0, A2,  64'h8,   0); // 14
      add(0, 1, 1, A3,  0,        1, 64'hC,   0, A2,  64'h8,   1); // 15
      add(0, 1, 0, 0,   0,        0, 64'hC,   1, A3,  64'hC,   0); // 16
      // flush in REQ with ack pending -> DRAIN, data discarded
      add(1, 1, 0, 0,   64'h100,  1, 64'h10,  0, A3,  64'hC,   1); // 17
      add(0, 1, 0, 0,   0,        1, 64'h10,  0, A3,  64'hC,   0); // 18 DRAIN
      add(0, 1, 1, BAD, 0,        1, 64'h10,  0, A3,  64'hC,   0); // 19 drain ack
      add(0, 1, 1, BAD, 0,        0, 64'h10,  0, A3,  64'hC,   0); // 20 IDLE
      add(0, 1, 1, A4,  0,        1, 64'h100, 0, A3,  64'hC,   1); // 21
      // flush together with id_ready in HOLD
      add(1, 1, 0, 0,   64'h200,  0, 64'h100, 1, A4,  64'h100, 1); // 22
      add(0, 1, 0, 0,   0,        0, 64'h100, 0, A4,  64'h100, 0); // 23 IDLE
      add(0, 1, 0, 0,   0,        1, 64'h200, 0, A4,  64'h100, 0); // 24
      // flush coincident with ack in REQ
      add(1, 1, 1, BAD, 64'h300,  1, 64'h200, 0, A4,  64'h100, 1); // 25
      add(0, 1, 0, 0,   0,        0, 64'h200, 0, A4,  64'h100, 0); // 26 IDLE
      // flush again while draining; flush while IDLE
      add(1, 1, 0, 0,   64'h400,  1, 64'h300, 0, A4,  64'h100, 1); // 27
      add(1, 1, 0, 0,   64'h500,  1, 64'h300, 0, A4,  64'h100, 1); // 28 DRAIN
      add(0, 1, 1, BAD, 0,        1, 64'h300, 0, A4,  64'h100, 0); // 29
      add(1, 1, 0, 0,   64'h600,  0, 64'h300, 0, A4,  64'h100, 1); // 30 IDLE
      add(0, 1, 0, 0,   0,        0, 64'h300, 0, A4,  64'h100, 0); // 31
      add(0, 1, 0, 0,   0,        1, 64'h600, 0, A4,  64'h100, 0); // 32 REQ

      rst_n = 1'b0; flush = 1'b0; id_ready = 1'b0; imem_ack = 1'b0;
      imem_rdata = '0; tgt = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst imem_req",  {63'd0, imem_req}, 64'd0);
      chk("rst imem_addr", imem_addr,          64'd0);
      chk("rst if_valid",  {63'd0, if_valid}, 64'd0);
      chk("rst if_instr",  {32'd0, if_instr}, {32'd0, NOP});
      chk("rst if_pc",     if_pc,              64'd0);
`ifdef IFETCH_PERF_EN
      chk("rst perf_stall_cnt", {32'd0, perf_stall_cnt}, 64'd0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         flush = vecs[i].f; id_ready = vecs[i].rdy; imem_ack = vecs[i].ack;
         imem_rdata = vecs[i].rdata; tgt = vecs[i].tgt;
         @(negedge clk);
         chk($sformatf("v%0d imem_req", i),  {63'd0, imem_req}, {63'd0, vecs[i].e_req});
         chk($sformatf("v%0d imem_addr", i), imem_addr,          vecs[i].e_addr);
         chk($sformatf("v%0d if_valid", i),  {63'd0, if_valid}, {63'd0, vecs[i].e_valid});
         chk($sformatf("v%0d if_instr", i),  {32'd0, if_instr}, {32'd0, vecs[i].e_instr});
         chk($sformatf("v%0d if_pc", i),     if_pc,              vecs[i].e_pc);
         chk($sformatf("v%0d pc_write", i),  {63'd0, pc_write}, {63'd0, vecs[i].e_pcw});
         if (i != vecs.size() - 1) begin
            @(posedge clk);
            #1;
         end
      end

`ifdef IFETCH_PERF_EN
      // Stall cycles: 12,13,14,17,18,24,27,28
      chk("perf_stall_cnt before reset", {32'd0, perf_stall_cnt}, 64'd8);
`endif

      // Asynchronous reset pulse in the middle of an outstanding REQ.
      #1 rst_n = 1'b0;
      #1;
      chk("async rst imem_req", {63'd0, imem_req}, 64'd0);
      chk("async rst if_valid", {63'd0, if_valid}, 64'd0);
      chk("async rst if_instr", {32'd0, if_instr}, {32'd0, NOP});
      chk("async rst imem_addr", imem_addr, 64'd0);
`ifdef IFETCH_PERF_EN
      chk("async rst perf_stall_cnt", {32'd0, perf_stall_cnt}, 64'd0);
`endif
      #1 rst_n = 1'b1;
      chk("pc after rst", pc_in, 64'h600);
      @(posedge clk);
      #1;
      chk("post rst imem_req",  {63'd0, imem_req}, 64'd1);
      chk("post rst imem_addr", imem_addr,          64'h600);
      chk("post rst if_valid",  {63'd0, if_valid}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_instr_fetch_unit

`default_nettype wire
